// File: rtl/decoder_3to8.sv
// One-hot LED column decoder: zero-latency combinational out/oor plus 1-cycle registered copies; always ready, no backpressure.
// Optional macro DECODER_SCAN_EN adds a free-running column scan counter selected by scan_mode.
module decoder_3to8 #(
  parameter int N = 8,
  parameter int W = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] in,
`ifdef DECODER_SCAN_EN
  input  logic         scan_mode,
  output logic [W-1:0] scan_idx,
`endif
  output logic [N-1:0] out,
  output logic [N-1:0] out_q,
  output logic         oor,
  output logic         oor_q
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("decoder_3to8: N=%0d outside legal range 2..8", N);
  end

  logic [W-1:0] idx;

`ifdef DECODER_SCAN_EN
  logic [W-1:0] scan_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (scan_mode) begin
      scan_cnt <= (scan_cnt == W'(N - 1)) ? '0 : scan_cnt + W'(1);
    end
  end

  assign scan_idx = scan_cnt;
  assign idx      = scan_mode ? scan_cnt : in;
`else
  assign idx = in;
`endif

  // Per-bit AND of an equality keeps synthesis strictly one-hot and lets X propagate in simulation.
  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      out[k] = ena & (idx == W'(k));
    end
  end

  // Full-width unsigned compare: in == N is out of range, never wraps to column 0.
  assign oor = ena & (idx >= W'(N));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      oor_q <= 1'b0;
    end else begin
      out_q <= out;
      oor_q <= oor;
    end
  end

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8 (N=8 and N=4 instances) against a behavioural index-to-strobe model.
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [3:0] in;
  logic [7:0] out, out_q;
  logic       oor, oor_q;

  logic       ena4;
  logic [2:0] in4;
  logic [3:0] out4, out4_q;
  logic       oor4, oor4_q;

  int total = 0;
  int bad   = 0;

`ifdef DECODER_SCAN_EN
  logic       scan_mode;
  logic [3:0] scan_idx;
  logic       scan_mode4;
  logic [2:0] scan_idx4;
`endif

  always #5 clk = ~clk;

  decoder_3to8 #(.N(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in),
`ifdef DECODER_SCAN_EN
    .scan_mode(scan_mode), .scan_idx(scan_idx),
`endif
    .out(out), .out_q(out_q), .oor(oor), .oor_q(oor_q)
  );

  decoder_3to8 #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena4), .in(in4),
`ifdef DECODER_SCAN_EN
    .scan_mode(scan_mode4), .scan_idx(scan_idx4),
`endif
    .out(out4), .out_q(out4_q), .oor(oor4), .oor_q(oor4_q)
  );

  // Reference: column idx lights exactly one line when enabled and in range.
  function automatic logic [7:0] ref_out(input logic e, input int idx, input int n);
    if (e && idx < n) return 8'(1 << idx);
    return 8'h00;
  endfunction

  function automatic logic ref_oor(input logic e, input int idx, input int n);
    return e && (idx >= n);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, check the combinational path, then the registered path after the edge.
  task automatic step(input logic r, input logic e, input logic [3:0] i, input string tag);
    logic [7:0] eo;
    logic       eoor;
    @(negedge clk);
    rst = r; ena = e; in = i;
    #1;
    eo   = ref_out(e, int'(i), 8);
    eoor = ref_oor(e, int'(i), 8);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".oor"}, 8'(oor), 8'(eoor));
    @(posedge clk);
    #1;
    chk({tag, ".out_q"}, out_q, r ? 8'h00 : eo);
    chk({tag, ".oor_q"}, 8'(oor_q), r ? 8'h00 : 8'(eoor));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; in = 4'd0; ena4 = 1'b0; in4 = 3'd0;
`ifdef DECODER_SCAN_EN
    scan_mode = 1'b0; scan_mode4 = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("reset.out_q", out_q, 8'h00);
    chk("reset.oor_q", 8'(oor_q), 8'h00);
    chk("reset.out4_q", 8'(out4_q), 8'h00);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'(i), "sweep");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i), "gate");
    step(1'b0, 1'b1, 4'd8, "oor8");
    step(1'b0, 1'b1, 4'd15, "oor15");

    step(1'b1, 1'b1, 4'd3, "rst_hold0");
    step(1'b1, 1'b1, 4'd3, "rst_hold1");
    step(1'b0, 1'b1, 4'd3, "rst_release");

    @(negedge clk);
    ena4 = 1'b1; in4 = 3'd3;
    #1;
    chk("n4.in3.out", 8'(out4), 8'h08);
    chk("n4.in3.oor", 8'(oor4), 8'h00);
    @(negedge clk);
    in4 = 3'd4;
    #1;
    chk("n4.in4.out", 8'(out4), 8'h00);
    chk("n4.in4.oor", 8'(oor4), 8'h01);
    @(posedge clk);
    #1;
    chk("n4.in4.oor_q", 8'(oor4_q), 8'h01);
    chk("n4.in4.out_q", 8'(out4_q), 8'h00);

    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), "rand");
    end

`ifdef DECODER_SCAN_EN
    @(negedge clk);
    rst = 1'b1; ena = 1'b1; in = 4'd12;
    @(negedge clk);
    rst = 1'b0; scan_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("scan.idx", 8'(scan_idx), 8'(c % 8));
      chk("scan.out", out, ref_out(1'b1, c % 8, 8));
      chk("scan.oor", 8'(oor), 8'h00);
      @(negedge clk);
    end
    scan_mode = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("scan.freeze", 8'(scan_idx), 8'd2);
      @(negedge clk);
    end
    chk("scan.off.oor", 8'(oor), 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
